// File: rtl/d_flip_flop.sv
// Single-register D flip-flop with asynchronous active-low reset to RST_VAL
// and a combinational complement output.
module d_flip_flop #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    // rst is active-low: it forces RST_VAL the moment it falls and keeps
    // overriding every clock edge until it is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

    assign qb = ~q;

endmodule

// File: tb/tb_d_flip_flop.sv
// Scoreboard bench for d_flip_flop: a 1-bit default instance and an 8-bit
// instance with a non-zero reset value run side by side.
module tb_d_flip_flop;

    logic       clk;
    logic       rst;
    logic       d1;
    logic       q1;
    logic       qb1;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] qb8;

    int checks   = 0;
    int failures = 0;

    logic       exp1_q[$];
    logic [7:0] exp8_q[$];

    d_flip_flop u_dff1 (
        .d   (d1),
        .clk (clk),
        .rst (rst),
        .q   (q1),
        .qb  (qb1)
    );

    d_flip_flop #(
        .WIDTH   (8),
        .RST_VAL (8'hA5)
    ) u_dff8 (
        .d   (d8),
        .clk (clk),
        .rst (rst),
        .q   (q8),
        .qb  (qb8)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive d, record what q must become at the
    // next rising edge, then compare just after that edge.
    task automatic step(input logic d1v, input logic [7:0] d8v, input string tag);
        logic       e1;
        logic [7:0] e8;
        d1 = d1v;
        d8 = d8v;
        exp1_q.push_back(d1v);
        exp8_q.push_back(d8v);
        @(posedge clk);
        #1;
        if (exp1_q.size() == 0 || exp8_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 8'd0, 8'd1);
        end else begin
            e1 = exp1_q.pop_front();
            e8 = exp8_q.pop_front();
            chk({tag, "_q1"},  {7'd0, q1},  {7'd0, e1});
            chk({tag, "_qb1"}, {7'd0, qb1}, {7'd0, ~e1});
            chk({tag, "_q8"},  q8,  e8);
            chk({tag, "_qb8"}, qb8, ~e8);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        d1  = 1'b1;
        d8  = 8'hFF;
        #2 rst = 1'b0;
        #1;
        chk("rst_async_q1",  {7'd0, q1},  8'h00);
        chk("rst_async_qb1", {7'd0, qb1}, 8'h01);
        chk("rst_async_q8",  q8,  8'hA5);
        chk("rst_async_qb8", qb8, 8'h5A);

        @(posedge clk);
        #1;
        chk("rst_hold_q1", {7'd0, q1}, 8'h00);
        chk("rst_hold_q8", q8, 8'hA5);

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("release_q1", {7'd0, q1}, 8'h00);
        chk("release_q8", q8, 8'hA5);
        #1;

        step(1'b1, 8'h3C, "hold1_a");
        step(1'b1, 8'h3C, "hold1_b");
        step(1'b1, 8'h3C, "hold1_c");

        step(1'b1, 8'h01, "seq_1");
        step(1'b0, 8'hFE, "seq_0");
        step(1'b1, 8'h80, "seq_1b");
        step(1'b0, 8'h00, "seq_0b");

        // d toggles inside the low phase; only the value at the edge counts
        d1 = 1'b1;  d8 = 8'h11;
        #3 d1 = 1'b0;  d8 = 8'h22;
        #3 d1 = 1'b1;  d8 = 8'h33;
        #1;
        chk("lowph_hold_q1", {7'd0, q1}, 8'h00);
        chk("lowph_hold_q8", q8, 8'h00);
        @(posedge clk);
        #1;
        chk("lowph_edge_q1", {7'd0, q1}, 8'h01);
        chk("lowph_edge_q8", q8, 8'h33);

        // d toggles inside the high phase; q must not move
        #2 d1 = 1'b0;  d8 = 8'h44;
        #2 d1 = 1'b1;  d8 = 8'h55;
        #2 d1 = 1'b0;  d8 = 8'h66;
        #1;
        chk("highph_hold_q1", {7'd0, q1}, 8'h01);
        chk("highph_hold_q8", q8, 8'h33);
        @(negedge clk);

        step(1'b1, 8'hC3, "pre_rst");

        // reset mid-operation, between edges, with q=1
        #3 rst = 1'b0;
        #1;
        chk("midrst_q1",  {7'd0, q1},  8'h00);
        chk("midrst_qb1", {7'd0, qb1}, 8'h01);
        chk("midrst_q8",  q8,  8'hA5);
        d1 = 1'b1;
        d8 = 8'h77;
        @(posedge clk);
        #1;
        chk("midrst_hold_q1", {7'd0, q1}, 8'h00);
        chk("midrst_hold_q8", q8, 8'hA5);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 8'h3C, "after_rst");
        step(1'b0, 8'h5A, "after_rst2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/d_flip_flop.md
D_FLIP_FLOP -- requirements
Module: d_flip_flop

Interface
REQ-001 Parameter WIDTH, default 1, data width of d, q and qb.
REQ-002 Parameter RST_VAL, default 0 (all bits), value loaded into q while reset is asserted.
REQ-003 clk  input  1  single clock for the block; all state updates occur on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (rst=0 asserts reset).
REQ-005 d  input  WIDTH  data input, sampled on rising clk edge.
REQ-006 q  output  WIDTH  registered data output.
REQ-007 qb  output  WIDTH  bitwise complement of q.
REQ-008 Positional port order SHALL be d, clk, rst, q, qb so existing positional instantiations bind correctly.

Function
REQ-009 The block SHALL hold one WIDTH-bit state register whose value drives q directly.
REQ-010 On each rising clk edge with rst=1, q SHALL take the value of d sampled at that edge; latency d->q is one edge.
REQ-011 Between rising edges q SHALL hold its value regardless of d activity, including d changes on the falling edge.
REQ-012 qb SHALL equal ~q at all times, combinationally; no edge or cycle in which qb == q for a known q.
REQ-013 No enable, no set input: every rising edge with rst=1 loads d.
REQ-014 Falling clk edges SHALL have no effect on q or qb.
REQ-015 Unknown (X/Z) bits on d at a rising edge SHALL propagate to the corresponding q bit; qb bits SHALL be their complement (X).
REQ-016 Before the first reset assertion, q is undefined; the block SHALL NOT rely on initial values.

Reset
REQ-017 When rst falls to 0, q SHALL become RST_VAL and qb ~RST_VAL immediately, without waiting for a clk edge.
REQ-018 While rst=0, q SHALL stay RST_VAL through any number of rising clk edges and any d activity.
REQ-019 Reset asserted mid-operation (q=1) SHALL override the stored value at once; the previous value is lost.
REQ-020 On rst rising to 1, q SHALL hold RST_VAL until the next rising clk edge with rst=1, which loads d.
REQ-021 If rst rises coincident with a rising clk edge, that edge SHALL NOT load d; capture starts at the following rising edge.

Verification
REQ-022 Clock 20 ns period, stimulus changed on falling edges; rst=0 for one cycle with d=1 -> q=0, qb=1 immediately and throughout reset.
REQ-023 After reset release, d sequence 1,0,1,0 applied one per cycle -> q follows 1,0,1,0 each at the next rising edge, qb=0,1,0,1.
REQ-024 q=1 held, rst driven to 0 between clock edges -> q=0, qb=1 before the next rising edge; held while rst=0 even with d=1.
REQ-025 Release reset with d=1 held for three cycles -> q=0 until first rising edge after release, then q=1, qb=0 for all three cycles.
REQ-026 d toggled 1->0->1 within a single high or low clock phase -> q unchanged until the next rising edge, then equals d at that edge.
REQ-027 WIDTH=8, RST_VAL=8'hA5: reset -> q=8'hA5, qb=8'h5A; d=8'h3C at a rising edge -> q=8'h3C, qb=8'hC3.
